// File: rtl/gf2m_pkg.sv
// Shared constants for the GF(2^m) field-arithmetic units: default reduction
// polynomials, controller state encoding and digit-count helper.
package gf2m_pkg;

  localparam logic [15:0] POLY_16 = 16'h002B;
  localparam logic [31:0] POLY_32 = 32'h0000_008D;
  localparam logic [63:0] POLY_64 = 64'h0000_0000_0000_001B;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int n_digits(input int m, input int d);
    return (m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One MSB-first digit step: acc*x^D + a*digit, reduced modulo x^M + POLY.
module gf2m_digit_step
  import gf2m_pkg::*;
#(
  parameter int          M    = 16,
  parameter int          D    = 4,
  parameter logic [M-1:0] POLY = M'(POLY_16)
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  output logic [M-1:0] acc_next
);

  localparam int          W   = M + D;
  localparam logic [W-1:0] RED = W'({1'b1, POLY});

  logic [W-1:0] a_ext_s;
  logic [W-1:0] prod_s;

  assign a_ext_s = W'(a);

  // Partial product then fold every bit above degree M-1 back, top bit first.
  always_comb begin
    prod_s = {acc, {D{1'b0}}};
    for (int j = 0; j < D; j++) begin
      prod_s = prod_s ^ ({W{digit[j]}} & (a_ext_s << j));
    end
    for (int i = W - 1; i >= M; i--) begin
      prod_s = prod_s ^ ({W{prod_s[i]}} & (RED << (i - M)));
    end
    acc_next = prod_s[M-1:0];
  end

endmodule

// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^M) multiplier with valid/ready handshake on both sides;
// one D-bit digit of b is consumed per BUSY cycle, most significant first.
module gf2m_digit_mul
  import gf2m_pkg::*;
#(
  parameter int           M    = 16,
  parameter int           D    = 4,
  parameter logic [M-1:0] POLY = M'(POLY_16)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] p
);

  localparam int N  = n_digits(M, D);
  localparam int BW = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   a_q, a_d;
  logic [BW-1:0]  b_q, b_d;
  logic [M-1:0]   acc_q, acc_d;
  logic [M-1:0]   p_q, p_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic [M-1:0]   step_s;

  gf2m_digit_step #(.M(M), .D(D), .POLY(POLY)) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .digit    (b_q[BW-1 -: D]),
    .acc_next (step_s)
  );

  // b is shifted left each step so the current digit is always the top D bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = BW'(b);
          acc_d   = {M{1'b0}};
          cnt_d   = CW'(N - 1);
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        acc_d = step_s;
        b_d   = b_q << D;
        if (cnt_q == {CW{1'b0}}) begin
          p_d     = step_s;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready && out_valid_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State, datapath and handshake flags; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      a_q         <= {M{1'b0}};
      b_q         <= {BW{1'b0}};
      acc_q       <= {M{1'b0}};
      p_q         <= {M{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Bench for gf2m_digit_mul: directed vectors on the default build, a
// transaction model checked every cycle, and random runs for D=3, 1, 16.
module tb_gf2m_digit_mul;

  localparam int          N    = 4;
  localparam logic [15:0] POLY = 16'h002B;

  logic        clk = 1'b0;
  logic        rst, rst_cfg;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, p;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  gf2m_digit_mul #(.M(16), .D(4), .POLY(POLY)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  // Reference: schoolbook shift-and-add over GF(2^16), LSB of b first.
  function automatic logic [15:0] gf_mul(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    logic [15:0] s;
    r = 16'h0000;
    s = x;
    for (int i = 0; i < 16; i++) begin
      if (y[i]) r = r ^ s;
      s = s[15] ? ((s << 1) ^ POLY) : (s << 1);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: a result is owed N cycles after acceptance until taken.
  logic        pending  = 1'b0;
  logic        in_rst_m = 1'b1;
  int          acc_cyc  = 0;
  logic [15:0] exp_p    = 16'h0000;
  logic        ready_m;

  assign ready_m = pending && ((cyc - acc_cyc) > N);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pending  <= 1'b0;
      in_rst_m <= 1'b1;
    end else begin
      in_rst_m <= 1'b0;
      if (in_valid && !pending && !in_rst_m) begin
        pending <= 1'b1;
        acc_cyc <= cyc;
        exp_p   <= gf_mul(a, b);
      end else if (ready_m && out_ready) begin
        pending <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_in_ready", {31'd0, in_ready}, {31'd0, !pending && !in_rst_m});
    check("cmp_out_valid", {31'd0, out_valid}, {31'd0, ready_m});
    if (ready_m) check("cmp_p", {16'd0, p}, {16'd0, exp_p});
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] exp, input string name);
    int w;
    int lat;
    @(negedge clk);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, lat, N);
    check(name, {16'd0, p}, {16'd0, exp});
  endtask

  // Random configurations sharing the reference model.
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int DG = (g == 0) ? 3 : ((g == 1) ? 1 : 16);
    localparam int NG = (16 + DG - 1) / DG;
    logic        iv, ir, ov, done_g;
    logic [15:0] ga, gb, gp;

    gf2m_digit_mul #(.M(16), .D(DG), .POLY(16'h002B)) u_cfg (
      .clk(clk), .rst(rst_cfg), .in_valid(iv), .in_ready(ir),
      .a(ga), .b(gb), .out_valid(ov), .out_ready(1'b1), .p(gp)
    );

    initial begin
      int w;
      int lat;
      done_g = 1'b0;
      iv = 1'b0;
      ga = 16'h0000;
      gb = 16'h0000;
      wait (rst_cfg === 1'b0);
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        ga = 16'($urandom);
        gb = 16'($urandom);
        iv = 1'b1;
        w = 0;
        while (!ir && w < 20) begin
          @(negedge clk);
          w++;
        end
        @(negedge clk);
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("cfg_D%0d_lat", DG), lat, NG);
        check($sformatf("cfg_D%0d_p", DG), {16'd0, gp}, {16'd0, gf_mul(ga, gb)});
      end
      done_g = 1'b1;
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    rst_cfg = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 16'h0000;
    b = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_p", {16'd0, p}, 32'd0);
    rst = 1'b0;
    rst_cfg = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(16'h0001, 16'hBEEF, 16'hBEEF, "unit_a");
    run_op(16'h8000, 16'h0002, 16'h002B, "x16_reduce");
    run_op(16'h8000, 16'h8000, 16'hC10E, "x30_reduce");
    run_op(16'h00FF, 16'h00FF, 16'h5555, "no_reduce");
    run_op(16'h0000, 16'hFFFF, 16'h0000, "zero_a");
    for (int k = 0; k < 20; k++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, gf_mul(ra, rb), "rand_d4");
    end

    // Back-to-back with in_valid held: per-cycle model enforces N+2 spacing.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h5678;
    in_valid = 1'b1;
    repeat (3 * (N + 2)) @(negedge clk);
    in_valid = 1'b0;
    repeat (N + 2) @(negedge clk);

    // Consumer stalls for 10 cycles in DONE while in_valid pulses.
    out_ready = 1'b0;
    a = 16'h8000;
    b = 16'h8000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_p", {16'd0, p}, 32'h0000_C10E);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = k[0];
      a = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset after two BUSY steps.
    a = 16'hA5A5;
    b = 16'h3C3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_p", {16'd0, p}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(16'h8000, 16'h0002, 16'h002B, "after_rst");

    t = 0;
    while (!(g_cfg[0].done_g && g_cfg[1].done_g && g_cfg[2].done_g) && t < 40000) begin
      @(negedge clk);
      t++;
    end
    check("cfg_timeout", {31'd0, t < 40000}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
